// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, load has priority over increment.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_value,
  input  logic              inc,
  output logic [WORD_W-1:0] pc
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;

  // Increment wraps naturally at 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (inc) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives program memory, captures the word, hands it to decode on valid/ready.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_read_data,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;
  logic [WORD_W-1:0] pc_load_value;
  logic              redirect_bad;
  logic              fault_active;

  assign pc_load_value = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);
  assign fault_d      = fault_q || redirect_bad;
  assign fault_active = fault_q;
  assign fetch_fault  = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign redirect_bad = 1'b0;
  assign fault_active = 1'b0;
`endif

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .load_value(pc_load_value),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect overrides every state; a fault parks the stage in IDLE until reset.
  always_comb begin
    state_d = state_q;
    if (redirect_bad || fault_active) begin
      state_d = IDLE;
    end else if (redirect) begin
      state_d = halt ? IDLE : REQ;
    end else begin
      case (state_q)
        IDLE:    if (!halt) state_d = REQ;
        REQ:     if (cnt_q == LAST_CNT) state_d = HOLD;
        HOLD:    if (instr_ready) state_d = halt ? IDLE : REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read    = (state_q == REQ);
    mem_address = pc;
  end

  always_comb begin
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    if (redirect_bad || fault_active) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (redirect) begin
      pc_load = 1'b1;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        REQ: begin
          if (cnt_q == LAST_CNT) begin
            instr_d  = mem_read_data;
            pc_out_d = pc;
            valid_d  = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            pc_inc  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// checked against a transaction-level model of the presented instruction stream.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  // DUT A: MEM_LATENCY=1, RESET_PC=0
  logic        a_rst_n;
  logic [31:0] a_mem_address;
  logic        a_mem_read;
  logic [31:0] a_mem_read_data;
  logic [31:0] a_instr_out;
  logic [31:0] a_pc_out;
  logic        a_instr_valid;
  logic        a_instr_ready;
  logic        a_redirect;
  logic [31:0] a_redirect_pc;
  logic        a_halt;
  logic        a_fetch_fault;

  // DUT B: MEM_LATENCY=3, RESET_PC=0xFFFFFFFC
  logic        b_rst_n;
  logic [31:0] b_mem_address;
  logic        b_mem_read;
  logic [31:0] b_mem_read_data;
  logic [31:0] b_instr_out;
  logic [31:0] b_pc_out;
  logic        b_instr_valid;
  logic        b_instr_ready;
  logic        b_redirect;
  logic [31:0] b_redirect_pc;
  logic        b_halt;
  logic        b_fetch_fault;

  assign a_mem_read_data = mem[a_mem_address[9:2]];
  assign b_mem_read_data = mem[b_mem_address[9:2]];

  instruction_fetch #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .mem_address(a_mem_address), .mem_read(a_mem_read),
    .mem_read_data(a_mem_read_data), .instr_out(a_instr_out), .pc_out(a_pc_out),
    .instr_valid(a_instr_valid), .instr_ready(a_instr_ready), .redirect(a_redirect),
    .redirect_pc(a_redirect_pc), .halt(a_halt)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_fault(a_fetch_fault)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .mem_address(b_mem_address), .mem_read(b_mem_read),
    .mem_read_data(b_mem_read_data), .instr_out(b_instr_out), .pc_out(b_pc_out),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready), .redirect(b_redirect),
    .redirect_pc(b_redirect_pc), .halt(b_halt)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_fault(b_fetch_fault)
`endif
  );

`ifndef FETCH_ALIGN_CHECK_EN
  assign a_fetch_fault = 1'b0;
  assign b_fetch_fault = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    a_rst_n       = 1'b0;
    a_redirect    = 1'b0;
    a_redirect_pc = 32'h0;
    a_halt        = 1'b0;
    a_instr_ready = 1'b1;
    repeat (3) tick();
    a_rst_n = 1'b1;
  endtask

  task automatic wait_valid_a(input logic [31:0] pc, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (a_instr_valid === 1'b1 && a_pc_out === pc) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    a_rst_n = 1'b0; a_redirect = 1'b0; a_redirect_pc = 32'h0; a_halt = 1'b0; a_instr_ready = 1'b1;
    repeat (3) tick();
    checks++; if (a_mem_read !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_read got=%0h exp=0", a_mem_read); end
    checks++; if (a_mem_address !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_address got=%0h exp=0", a_mem_address); end
    checks++; if (a_instr_valid !== 1'b0 || a_instr_out !== 32'h0 || a_pc_out !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_outputs got valid=%0h instr=%0h pc=%0h exp=0/0/0", a_instr_valid, a_instr_out, a_pc_out); end
    checks++; if (a_fetch_fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault got=%0h exp=0", a_fetch_fault); end
    a_rst_n = 1'b1;
    #1;
    checks++; if (a_mem_read !== 1'b0) begin failures++; $display("[TB] FAIL release_idle got=%0h exp=0", a_mem_read); end
    tick();
    checks++; if (a_mem_read !== 1'b1 || a_mem_address !== 32'h0 || a_instr_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL first_req got rd=%0h addr=%0h v=%0h exp=1/0/0", a_mem_read, a_mem_address, a_instr_valid); end
    tick();
    checks++; if (a_instr_valid !== 1'b1 || a_instr_out !== 32'h1111_1111 || a_pc_out !== 32'h0 || a_mem_read !== 1'b0) begin
      failures++; $display("[TB] FAIL first_word got v=%0h instr=%0h pc=%0h rd=%0h exp=1/11111111/0/0", a_instr_valid, a_instr_out, a_pc_out, a_mem_read); end
    tick();
    checks++; if (a_instr_valid !== 1'b0 || a_mem_read !== 1'b1 || a_mem_address !== 32'h4) begin
      failures++; $display("[TB] FAIL second_req got v=%0h rd=%0h addr=%0h exp=0/1/4", a_instr_valid, a_mem_read, a_mem_address); end
    tick();
    checks++; if (a_instr_valid !== 1'b1 || a_instr_out !== 32'h2222_2222 || a_pc_out !== 32'h4) begin
      failures++; $display("[TB] FAIL second_word got v=%0h instr=%0h pc=%0h exp=1/22222222/4", a_instr_valid, a_instr_out, a_pc_out); end
  endtask

  task automatic test_backpressure();
    bit found;
    mem[1] = 32'h1234_5678;
    reset_a();
    wait_valid_a(32'h0, found);
    checks++; if (!found) begin failures++; $display("[TB] FAIL bp_first_valid got=timeout exp=pc0"); end
    tick();
    a_instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_instr_valid !== 1'b1 || a_instr_out !== 32'h1234_5678 || a_pc_out !== 32'h4 ||
                    a_mem_read !== 1'b0 || a_mem_address !== 32'h4) begin
        failures++; $display("[TB] FAIL bp_hold%0d got v=%0h instr=%0h pc=%0h rd=%0h addr=%0h exp=1/12345678/4/0/4",
                             i, a_instr_valid, a_instr_out, a_pc_out, a_mem_read, a_mem_address); end
      tick();
    end
    a_instr_ready = 1'b1;
    tick();
    checks++; if (a_instr_valid !== 1'b0 || a_mem_address !== 32'h8 || a_mem_read !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_accept got v=%0h addr=%0h rd=%0h exp=0/8/1", a_instr_valid, a_mem_address, a_mem_read); end
  endtask

  task automatic test_redirect_ready_hold();
    bit found;
    reset_a();
    wait_valid_a(32'h0, found);
    checks++; if (!found) begin failures++; $display("[TB] FAIL rr_first_valid got=timeout exp=pc0"); end
    tick();
    a_instr_ready = 1'b0;
    tick();
    checks++; if (a_instr_valid !== 1'b1 || a_pc_out !== 32'h4) begin
      failures++; $display("[TB] FAIL rr_hold4 got v=%0h pc=%0h exp=1/4", a_instr_valid, a_pc_out); end
    a_instr_ready = 1'b1; a_redirect = 1'b1; a_redirect_pc = 32'h40;
    tick();
    a_redirect = 1'b0;
    checks++; if (a_instr_valid !== 1'b0 || a_mem_address !== 32'h40 || a_mem_read !== 1'b1) begin
      failures++; $display("[TB] FAIL rr_target got v=%0h addr=%0h rd=%0h exp=0/40/1", a_instr_valid, a_mem_address, a_mem_read); end
    tick();
    checks++; if (a_instr_valid !== 1'b1 || a_pc_out !== 32'h40 || a_instr_out !== mem[16]) begin
      failures++; $display("[TB] FAIL rr_word got v=%0h pc=%0h instr=%0h exp=1/40/%0h", a_instr_valid, a_pc_out, a_instr_out, mem[16]); end
  endtask

  task automatic test_halt();
    bit found;
    reset_a();
    a_instr_ready = 1'b0;
    wait_valid_a(32'h0, found);
    checks++; if (!found) begin failures++; $display("[TB] FAIL halt_first_valid got=timeout exp=pc0"); end
    a_halt = 1'b1; a_instr_ready = 1'b1;
    tick();
    checks++; if (a_instr_valid !== 1'b0 || a_mem_read !== 1'b0 || a_mem_address !== 32'h4) begin
      failures++; $display("[TB] FAIL halt_idle got v=%0h rd=%0h addr=%0h exp=0/0/4", a_instr_valid, a_mem_read, a_mem_address); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (a_mem_read !== 1'b0) begin failures++; $display("[TB] FAIL halt_stay%0d got=%0h exp=0", i, a_mem_read); end
    end
    a_halt = 1'b0;
    tick();
    checks++; if (a_mem_read !== 1'b1 || a_mem_address !== 32'h4) begin
      failures++; $display("[TB] FAIL halt_resume got rd=%0h addr=%0h exp=1/4", a_mem_read, a_mem_address); end
    tick();
    checks++; if (a_instr_valid !== 1'b1 || a_pc_out !== 32'h4 || a_instr_out !== mem[1]) begin
      failures++; $display("[TB] FAIL halt_word got v=%0h pc=%0h instr=%0h exp=1/4/%0h", a_instr_valid, a_pc_out, a_instr_out, mem[1]); end
  endtask

  task automatic test_wrap_redirect();
    mem[2] = 32'h8765_4321;
    b_rst_n = 1'b0; b_instr_ready = 1'b1; b_halt = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'h0;
    repeat (2) tick();
    b_rst_n = 1'b1;
    tick();
    checks++; if (b_mem_read !== 1'b1 || b_mem_address !== 32'hFFFF_FFFC) begin
      failures++; $display("[TB] FAIL wrap_req got rd=%0h addr=%0h exp=1/fffffffc", b_mem_read, b_mem_address); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (b_instr_valid !== 1'b0 || b_mem_read !== 1'b1) begin
        failures++; $display("[TB] FAIL wrap_latency%0d got v=%0h rd=%0h exp=0/1", i, b_instr_valid, b_mem_read); end
    end
    tick();
    checks++; if (b_instr_valid !== 1'b1 || b_pc_out !== 32'hFFFF_FFFC || b_instr_out !== mem[255]) begin
      failures++; $display("[TB] FAIL wrap_word got v=%0h pc=%0h instr=%0h exp=1/fffffffc/%0h", b_instr_valid, b_pc_out, b_instr_out, mem[255]); end
    tick();
    checks++; if (b_mem_address !== 32'h0 || b_mem_read !== 1'b1) begin
      failures++; $display("[TB] FAIL wrap_pc got addr=%0h rd=%0h exp=0/1", b_mem_address, b_mem_read); end
    tick();
    b_redirect = 1'b1; b_redirect_pc = 32'h8;
    tick();
    b_redirect = 1'b0;
    checks++; if (b_instr_valid !== 1'b0 || b_mem_address !== 32'h8) begin
      failures++; $display("[TB] FAIL midfetch_redirect got v=%0h addr=%0h exp=0/8", b_instr_valid, b_mem_address); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (b_instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL midfetch_discard%0d got=%0h exp=0", i, b_instr_valid); end
    end
    tick();
    checks++; if (b_instr_valid !== 1'b1 || b_pc_out !== 32'h8 || b_instr_out !== 32'h8765_4321) begin
      failures++; $display("[TB] FAIL midfetch_word got v=%0h pc=%0h instr=%0h exp=1/8/87654321", b_instr_valid, b_pc_out, b_instr_out); end
    b_rst_n = 1'b0;
  endtask

  task automatic test_align();
    reset_a();
    repeat (3) tick();
    a_redirect = 1'b1; a_redirect_pc = 32'h6;
    tick();
    a_redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (a_fetch_fault !== 1'b1 || a_mem_read !== 1'b0 || a_instr_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL align_fault got f=%0h rd=%0h v=%0h exp=1/0/0", a_fetch_fault, a_mem_read, a_instr_valid); end
    for (int i = 0; i < 6; i++) begin
      a_redirect    = (i == 2);
      a_redirect_pc = 32'h10;
      tick();
      checks++; if (a_fetch_fault !== 1'b1 || a_mem_read !== 1'b0) begin
        failures++; $display("[TB] FAIL align_sticky%0d got f=%0h rd=%0h exp=1/0", i, a_fetch_fault, a_mem_read); end
    end
    reset_a();
    checks++; if (a_fetch_fault !== 1'b0) begin failures++; $display("[TB] FAIL align_clear got=%0h exp=0", a_fetch_fault); end
`else
    checks++; if (a_mem_address !== 32'h4 || a_mem_read !== 1'b1) begin
      failures++; $display("[TB] FAIL align_ignore got addr=%0h rd=%0h exp=4/1", a_mem_address, a_mem_read); end
    tick();
    checks++; if (a_instr_valid !== 1'b1 || a_pc_out !== 32'h4) begin
      failures++; $display("[TB] FAIL align_word got v=%0h pc=%0h exp=1/4", a_instr_valid, a_pc_out); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] target;
    logic        pv;
    logic [31:0] ppc;
    logic [31:0] pin;
    int          idle_run;
    int          max_idle;
    reset_a();
    exp_pc   = 32'h0;
    idle_run = 0;
    max_idle = 0;
    for (int n = 0; n < 400; n++) begin
      a_instr_ready = ($urandom_range(0, 3) != 0);
      a_halt        = ($urandom_range(0, 7) == 0);
      a_redirect    = ($urandom_range(0, 15) == 0);
      a_redirect_pc = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      a_redirect_pc[1:0] = 2'b00;
`endif
      target = a_redirect_pc & ~32'h3;
      pv  = a_instr_valid;
      ppc = a_pc_out;
      pin = a_instr_out;
      tick();
      if (a_redirect) exp_pc = target;
      else if (pv && a_instr_ready) exp_pc = exp_pc + 32'd4;
      if (a_redirect) begin
        checks++; if (a_instr_valid !== 1'b0) begin
          failures++; $display("[TB] FAIL rand_flush n=%0d got=%0h exp=0", n, a_instr_valid); end
      end else if (pv && !a_instr_ready) begin
        checks++; if (a_instr_valid !== 1'b1 || a_pc_out !== ppc || a_instr_out !== pin) begin
          failures++; $display("[TB] FAIL rand_stable n=%0d got v=%0h pc=%0h instr=%0h exp=1/%0h/%0h", n, a_instr_valid, a_pc_out, a_instr_out, ppc, pin); end
      end
      if (a_instr_valid === 1'b1) begin
        checks++; if (a_pc_out !== exp_pc || a_instr_out !== mem[exp_pc[9:2]]) begin
          failures++; $display("[TB] FAIL rand_stream n=%0d got pc=%0h instr=%0h exp=%0h/%0h", n, a_pc_out, a_instr_out, exp_pc, mem[exp_pc[9:2]]); end
      end
      if (a_instr_valid === 1'b1 || a_redirect) idle_run = 0;
      else idle_run++;
      if (idle_run > max_idle) max_idle = idle_run;
    end
    a_redirect = 1'b0;
    a_halt     = 1'b0;
    checks++; if (max_idle > 30) begin
      failures++; $display("[TB] FAIL rand_progress got idle=%0d exp<=30", max_idle); end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    b_rst_n = 1'b0; b_instr_ready = 1'b1; b_halt = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'h0;
    test_reset();
    test_backpressure();
    test_redirect_ready_hold();
    test_halt();
    test_wrap_redirect();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
